// File: rtl/elevator.sv
// Single-car SCAN elevator controller with one-hot floor position.
// Latches rising-edge floor calls, steps the car one floor per MOVE_CYCLES,
// dwells DOOR_CYCLES at each called floor and keeps direction while calls remain ahead.
module elevator #(
   parameter int unsigned NUM_FLOORS  = 5,
   parameter int unsigned MOVE_CYCLES = 2,
   parameter int unsigned DOOR_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] floor_req,
   output logic [NUM_FLOORS-1:0] floor_pos
);

   localparam int unsigned NF  = NUM_FLOORS;
   localparam int unsigned MCW = $clog2(MOVE_CYCLES + 1);
   localparam int unsigned DCW = $clog2(DOOR_CYCLES + 1);
   localparam logic        DIR_UP = 1'b1;
   localparam logic        DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DN   = 2'd2,
      DOOR_OPEN = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic [NF-1:0]    pos_q, pos_d;
   logic [NF-1:0]    pending_q, pending_d;
   logic [NF-1:0]    req_hist_q, req_hist_d;
   logic [MCW-1:0]   move_cnt_q, move_cnt_d;
   logic [DCW-1:0]   door_cnt_q, door_cnt_d;

   logic [NF-1:0]    new_calls;
   logic [NF-1:0]    svc_mask;
   logic [NF-1:0]    below_cur, above_cur;
   logic             calls_up, calls_dn, ahead, behind;
   logic [NF-1:0]    step_pos, step_below, step_above;
   logic             step_ahead, blocked;

   // Call edge detection and pending-call geometry relative to the car.
   assign new_calls  = floor_req & ~req_hist_q;
   assign below_cur  = pos_q - NF'(1);
   assign above_cur  = ~(below_cur | pos_q);
   assign calls_up   = |(pending_q & above_cur);
   assign calls_dn   = |(pending_q & below_cur);
   assign ahead      = (dir_q == DIR_UP) ? calls_up : calls_dn;
   assign behind     = (dir_q == DIR_UP) ? calls_dn : calls_up;

   // Floor the car would reach on a shift, and whether calls lie beyond it.
   assign step_pos   = (state_q == MOVE_DN) ? (pos_q >> 1) : (pos_q << 1);
   assign step_below = step_pos - NF'(1);
   assign step_above = ~(step_below | step_pos);
   assign step_ahead = (state_q == MOVE_DN) ? |(pending_q & step_below)
                                            : |(pending_q & step_above);
   assign blocked    = ((state_q == MOVE_UP) && pos_q[NF-1]) ||
                       ((state_q == MOVE_DN) && pos_q[0]);

   // Next-state, motion, call bookkeeping and direction logic.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      pos_d      = pos_q;
      move_cnt_d = move_cnt_q;
      door_cnt_d = door_cnt_q;
      req_hist_d = floor_req;
      svc_mask   = '0;

      case (state_q)
         IDLE: begin
            if (|((pending_q | new_calls) & pos_q)) begin
               state_d    = DOOR_OPEN;
               door_cnt_d = '0;
               svc_mask   = pos_q;
            end else if (ahead) begin
               state_d    = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DN;
               move_cnt_d = '0;
            end else if (behind) begin
               dir_d      = ~dir_q;
               state_d    = (dir_q == DIR_UP) ? MOVE_DN : MOVE_UP;
               move_cnt_d = '0;
            end
         end

         MOVE_UP, MOVE_DN: begin
            if (move_cnt_q == MCW'(MOVE_CYCLES - 1)) begin
               move_cnt_d = '0;
               if (blocked) begin
                  state_d = IDLE;
               end else begin
                  pos_d = step_pos;
                  if (|(pending_q & step_pos)) begin
                     state_d    = DOOR_OPEN;
                     door_cnt_d = '0;
                     svc_mask   = step_pos;
                  end else if (!step_ahead) begin
                     state_d = IDLE;
                  end
               end
            end else begin
               move_cnt_d = move_cnt_q + MCW'(1);
            end
         end

         DOOR_OPEN: begin
            // New calls for the floor being serviced are absorbed.
            svc_mask = pos_q;
            if (door_cnt_q == DCW'(DOOR_CYCLES - 1)) begin
               door_cnt_d = '0;
               if (ahead) begin
                  state_d    = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DN;
                  move_cnt_d = '0;
               end else if (behind) begin
                  dir_d      = ~dir_q;
                  state_d    = (dir_q == DIR_UP) ? MOVE_DN : MOVE_UP;
                  move_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               door_cnt_d = door_cnt_q + DCW'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      pending_d = (pending_q | new_calls) & ~svc_mask;

      // Direction is pinned at the shaft ends.
      if (pos_d[NF-1]) begin
         dir_d = DIR_DN;
      end else if (pos_d[0]) begin
         dir_d = DIR_UP;
      end
   end

   // State register; reset returns the car to floor 1 and drops all calls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         dir_q      <= DIR_UP;
         pos_q      <= NF'(1);
         pending_q  <= '0;
         req_hist_q <= '0;
         move_cnt_q <= '0;
         door_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         pos_q      <= pos_d;
         pending_q  <= pending_d;
         req_hist_q <= req_hist_d;
         move_cnt_q <= move_cnt_d;
         door_cnt_q <= door_cnt_d;
      end
   end

   assign floor_pos = pos_q;

endmodule

// File: tb/tb_elevator.sv
// Self-checking bench for elevator: expected floor changes (floor, edge index)
// are queued when calls are driven and matched as floor_pos changes.
module tb_elevator;

   localparam int unsigned NF = 5;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic [NF-1:0] floor_req = '0;
   logic [NF-1:0] floor_pos;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [NF-1:0] pos;
      int            cyc;
   } exp_t;

   exp_t          sb_q[$];
   logic [NF-1:0] last_pos = 5'b00001;

   elevator #(
      .NUM_FLOORS (5),
      .MOVE_CYCLES(2),
      .DOOR_CYCLES(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .floor_req(floor_req),
      .floor_pos(floor_pos)
   );

   // 10-unit clock; cyc holds the index of the most recent rising edge.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(input logic [NF-1:0] pos, input int c);
      exp_t e;
      e.pos = pos;
      e.cyc = c;
      sb_q.push_back(e);
   endtask

   // Advance to the next falling edge and match any floor change against the queue.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         last_pos = floor_pos;
      end else begin
         checks++;
         if (!$onehot(floor_pos)) begin
            failures++;
            $display("FAIL onehot cyc=%0d floor_pos=%b", cyc, floor_pos);
         end
         if (floor_pos !== last_pos) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_move cyc=%0d floor_pos=%b prev=%b", cyc, floor_pos, last_pos);
            end else begin
               e = sb_q.pop_front();
               if (floor_pos !== e.pos || cyc !== e.cyc) begin
                  failures++;
                  $display("FAIL move_event floor_pos=%b cyc=%0d expected floor_pos=%b cyc=%0d",
                           floor_pos, cyc, e.pos, e.cyc);
               end
            end
            last_pos = floor_pos;
         end
      end
   endtask

   // Wait (bounded) for every queued floor change to be observed.
   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout outstanding=%0d expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic do_reset();
      floor_req = '0;
      reset     = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      sb_q.delete();
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      floor_req = '0;
      tick();
      tick();
      checks++;
      if (floor_pos !== 5'b00001) begin
         failures++;
         $display("FAIL reset_pos floor_pos=%b expected 00001", floor_pos);
      end
      reset = 1'b1;
      repeat (8) tick();
      checks++;
      if (floor_pos !== 5'b00001) begin
         failures++;
         $display("FAIL idle_hold floor_pos=%b expected 00001", floor_pos);
      end
   endtask

   task automatic test_single_call();
      int l;
      do_reset();
      floor_req = 5'b00100;
      l = cyc + 1;
      push_exp(5'b00010, l + 3);
      push_exp(5'b00100, l + 5);
      drain(30);
      repeat (15) tick();
      checks++;
      if (floor_pos !== 5'b00100) begin
         failures++;
         $display("FAIL single_call_final floor_pos=%b expected 00100", floor_pos);
      end
      floor_req = '0;
      repeat (3) tick();
   endtask

   task automatic test_sequence();
      int l;
      do_reset();
      floor_req = 5'b00010;
      l = cyc + 1;
      push_exp(5'b00010, l + 3);
      tick();
      floor_req = '0;
      repeat (9) tick();
      floor_req = 5'b01000;
      l = cyc + 1;
      push_exp(5'b00100, l + 3);
      push_exp(5'b01000, l + 5);
      tick();
      floor_req = '0;
      repeat (9) tick();
      floor_req = 5'b00001;
      l = cyc + 1;
      push_exp(5'b00100, l + 3);
      push_exp(5'b00010, l + 5);
      push_exp(5'b00001, l + 7);
      tick();
      floor_req = '0;
      drain(40);
      repeat (5) tick();
      checks++;
      if (floor_pos !== 5'b00001) begin
         failures++;
         $display("FAIL sequence_final floor_pos=%b expected 00001", floor_pos);
      end
   endtask

   task automatic test_multi_call();
      int l;
      do_reset();
      floor_req = 5'b01010;
      l = cyc + 1;
      push_exp(5'b00010, l + 3);
      push_exp(5'b00100, l + 8);
      push_exp(5'b01000, l + 10);
      drain(40);
      repeat (10) tick();
      checks++;
      if (floor_pos !== 5'b01000) begin
         failures++;
         $display("FAIL multi_call_final floor_pos=%b expected 01000", floor_pos);
      end
      floor_req = '0;
      tick();
   endtask

   task automatic test_en_route();
      int l;
      do_reset();
      floor_req = 5'b10000;
      l = cyc + 1;
      push_exp(5'b00010, l + 3);
      push_exp(5'b00100, l + 5);
      push_exp(5'b01000, l + 7);
      push_exp(5'b10000, l + 12);
      push_exp(5'b01000, l + 17);
      push_exp(5'b00100, l + 19);
      push_exp(5'b00010, l + 21);
      tick();
      floor_req = '0;
      while (cyc < l + 3) tick();
      floor_req = 5'b01000;
      tick();
      floor_req = '0;
      tick();
      floor_req = 5'b00010;
      tick();
      floor_req = '0;
      drain(60);
      repeat (5) tick();
      checks++;
      if (floor_pos !== 5'b00010) begin
         failures++;
         $display("FAIL en_route_final floor_pos=%b expected 00010", floor_pos);
      end
   endtask

   task automatic test_async_reset();
      int l;
      do_reset();
      floor_req = 5'b10000;
      l = cyc + 1;
      push_exp(5'b00010, l + 3);
      push_exp(5'b00100, l + 5);
      tick();
      floor_req = '0;
      drain(20);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (floor_pos !== 5'b00001) begin
         failures++;
         $display("FAIL async_reset floor_pos=%b expected 00001", floor_pos);
      end
      tick();
      tick();
      reset = 1'b1;
      repeat (20) tick();
      checks++;
      if (floor_pos !== 5'b00001) begin
         failures++;
         $display("FAIL calls_dropped floor_pos=%b expected 00001", floor_pos);
      end
   endtask

   initial begin
      test_reset();
      test_single_call();
      test_sequence();
      test_multi_call();
      test_en_route();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
